// File: rtl/gpio_ctrl_pkg.sv
// gpio_ctrl_pkg
// Shared definitions for the GPIO controller:
//   GPIO_W_DEF / EVT_DEPTH_DEF : default port width and event FIFO depth
//   cap_state_t                : input-capture sequencer states
//   gpio_evt_t                 : one queued event, {gpio snapshot, ext strobe flag}
// The FIFO word inside gpio_ctrl uses the same {gpio, ext} packing as gpio_evt_t,
// so a default-width FIFO word can be cast directly to gpio_evt_t.
package gpio_ctrl_pkg;

  localparam int GPIO_W_DEF    = 32;
  localparam int EVT_DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } cap_state_t;

  typedef struct packed {
    logic [GPIO_W_DEF-1:0] gpio;
    logic                  ext;
  } gpio_evt_t;

endpackage

// File: rtl/gpio_evt_fifo.sv
// gpio_evt_fifo
// Show-ahead event FIFO: head_data always presents the oldest entry.
// Ports:
//   clk, rst            : clock, synchronous active-high reset (empties the FIFO)
//   push, push_data     : write request; taken when not full, or when full with a pop
//   pop                 : remove the head entry (ignored when empty)
//   head_data           : oldest entry (contents undefined while empty)
//   full, empty         : occupancy flags
// A push into an empty FIFO becomes visible on the following cycle; there is
// no bypass from push_data to head_data.
module gpio_evt_fifo
  import gpio_ctrl_pkg::*;
#(
  parameter int DATA_W = GPIO_W_DEF + 1,
  parameter int DEPTH  = EVT_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              do_push;
  logic              do_pop;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push   = push && (!full || pop);
  assign do_pop    = pop && !empty;
  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign head_data = mem[rd_ptr];

  // Storage has no reset; emptiness is tracked purely by count.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (do_push && !do_pop) begin
        count <= count + (AW+1)'(1);
      end else if (do_pop && !do_push) begin
        count <= count - (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/gpio_ctrl.sv
// gpio_ctrl
// GPIO controller with two independent halves:
//   * a two-requester write arbiter driving the registered gpio_out with
//     per-bit masked writes (alternating priority when both request), and
//   * an input-capture path that synchronizes gpio_in and ext_clk, detects
//     pin changes and ext_clk rising edges, and queues {gpio, ext} events.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   req_valid/req_ready   : per-requester write handshake (ready is combinational)
//   req_data/req_mask     : requester i at [i*GPIO_W +: GPIO_W]
//   gpio_out              : registered drive value
//   gpio_in, ext_clk      : asynchronous inputs
//   evt_valid/evt_ready   : event queue head handshake
//   evt_gpio, evt_ext     : head event payload, forced to 0 while empty
//   evt_drop_cnt          : saturating count of events lost to a full queue
module gpio_ctrl
  import gpio_ctrl_pkg::*;
#(
  parameter int GPIO_W    = GPIO_W_DEF,
  parameter int EVT_DEPTH = EVT_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [2*GPIO_W-1:0] req_data,
  input  logic [2*GPIO_W-1:0] req_mask,
  output logic [GPIO_W-1:0] gpio_out,
  input  logic [GPIO_W-1:0] gpio_in,
  input  logic              ext_clk,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [GPIO_W-1:0] evt_gpio,
  output logic              evt_ext,
  output logic [7:0]        evt_drop_cnt
);

  localparam int EVT_W = GPIO_W + 1;

  // ---------------- write arbiter ----------------
  logic              prio;
  logic              grant_valid;
  logic              grant_idx;
  logic [GPIO_W-1:0] sel_data;
  logic [GPIO_W-1:0] sel_mask;

  // Single requester wins outright; a tie goes to the prio index.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = 1'b0;
    case (req_valid)
      2'b01: begin grant_valid = 1'b1; grant_idx = 1'b0; end
      2'b10: begin grant_valid = 1'b1; grant_idx = 1'b1; end
      2'b11: begin grant_valid = 1'b1; grant_idx = prio; end
      default: begin grant_valid = 1'b0; grant_idx = 1'b0; end
    endcase
  end

  assign req_ready[0] = !rst && grant_valid && !grant_idx;
  assign req_ready[1] = !rst && grant_valid &&  grant_idx;
  assign sel_data     = grant_idx ? req_data[GPIO_W +: GPIO_W] : req_data[0 +: GPIO_W];
  assign sel_mask     = grant_idx ? req_mask[GPIO_W +: GPIO_W] : req_mask[0 +: GPIO_W];

  // After any grant, priority moves to the requester that was not served.
  always_ff @(posedge clk) begin
    if (rst) begin
      gpio_out <= '0;
      prio     <= 1'b0;
    end else if (grant_valid) begin
      gpio_out <= (gpio_out & ~sel_mask) | (sel_data & sel_mask);
      prio     <= ~grant_idx;
    end
  end

  // ---------------- input capture ----------------
  logic [GPIO_W-1:0] gpio_s1;
  logic [GPIO_W-1:0] gpio_s2;
  logic [GPIO_W-1:0] last_sample;
  logic              ext_s1;
  logic              ext_s2;
  logic              ext_s3;
  logic              ext_rise;
  cap_state_t        cap_state;
  logic              init_cnt;
  logic              push_req;
  logic              evt_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [EVT_W-1:0]  fifo_head;

  // Two-flop synchronizers; ext_s3 is the extra stage for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      gpio_s1 <= '0;
      gpio_s2 <= '0;
      ext_s1  <= 1'b0;
      ext_s2  <= 1'b0;
      ext_s3  <= 1'b0;
    end else begin
      gpio_s1 <= gpio_in;
      gpio_s2 <= gpio_s1;
      ext_s1  <= ext_clk;
      ext_s2  <= ext_s1;
      ext_s3  <= ext_s2;
    end
  end

  assign ext_rise = ext_s2 && !ext_s3;

  // INIT waits two cycles for the synchronizers to fill with real pin data,
  // PRIME seeds last_sample so the first RUN cycle does not see a bogus change.
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_state   <= INIT;
      init_cnt    <= 1'b0;
      last_sample <= '0;
    end else begin
      case (cap_state)
        INIT: begin
          init_cnt <= 1'b1;
          if (init_cnt) begin
            cap_state <= PRIME;
          end
        end
        PRIME: begin
          last_sample <= gpio_s2;
          cap_state   <= RUN;
        end
        RUN: begin
          last_sample <= gpio_s2;
        end
        default: begin
          cap_state <= INIT;
        end
      endcase
    end
  end

  // A pin change and an ext_clk edge in the same cycle merge into one event.
  assign push_req = (cap_state == RUN) && ((gpio_s2 != last_sample) || ext_rise);
  assign evt_pop  = evt_valid && evt_ready;

  gpio_evt_fifo #(
    .DATA_W (EVT_W),
    .DEPTH  (EVT_DEPTH)
  ) u_evt_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_req),
    .push_data ({gpio_s2, ext_rise}),
    .pop       (evt_pop),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign evt_valid = !fifo_empty;
  assign evt_gpio  = fifo_empty ? '0 : fifo_head[EVT_W-1:1];
  assign evt_ext   = !fifo_empty && fifo_head[0];

  // An event is lost only when the queue is full and the head is not leaving.
  always_ff @(posedge clk) begin
    if (rst) begin
      evt_drop_cnt <= 8'd0;
    end else if (push_req && fifo_full && !evt_pop && (evt_drop_cnt != 8'hFF)) begin
      evt_drop_cnt <= evt_drop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_gpio_ctrl.sv
// tb_gpio_ctrl
// Self-checking bench for gpio_ctrl: a table of arbiter vectors, hand-written
// capture/FIFO sequences, and a randomized phase, all compared cycle by cycle
// against a behavioural model built from queues and input history.
module tb_gpio_ctrl;
  import gpio_ctrl_pkg::*;

  localparam int W = 32;
  localparam int D = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [1:0]     req_valid;
  logic [1:0]     req_ready;
  logic [2*W-1:0] req_data;
  logic [2*W-1:0] req_mask;
  logic [W-1:0]   gpio_out;
  logic [W-1:0]   gpio_in;
  logic           ext_clk;
  logic           evt_valid;
  logic           evt_ready;
  logic [W-1:0]   evt_gpio;
  logic           evt_ext;
  logic [7:0]     evt_drop_cnt;

  int checks_total  = 0;
  int checks_passed = 0;

  always #5 clk = ~clk;

  gpio_ctrl #(.GPIO_W(W), .EVT_DEPTH(D)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_data     (req_data),
    .req_mask     (req_mask),
    .gpio_out     (gpio_out),
    .gpio_in      (gpio_in),
    .ext_clk      (ext_clk),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .evt_gpio     (evt_gpio),
    .evt_ext      (evt_ext),
    .evt_drop_cnt (evt_drop_cnt)
  );

  // Reference model: gpio_out value, tie priority, event queue, drop count,
  // and a history of the last three pin samples (index 0 = newest).
  logic [W-1:0] m_out;
  logic         m_prio;
  gpio_evt_t    m_q[$];
  int           m_drop;
  logic [W-1:0] g_hist [3];
  logic         e_hist [3];
  int           m_phase;
  logic [W-1:0] m_last;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks_total++;
    if (actual === expected) begin
      checks_passed++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [1:0] model_ready();
    if (rst || req_valid == 2'b00) return 2'b00;
    if (req_valid == 2'b11) return m_prio ? 2'b10 : 2'b01;
    return req_valid;
  endfunction

  // Advance the model by one rising edge using the inputs present at that edge.
  task automatic model_edge();
    logic         g;
    logic [W-1:0] d;
    logic [W-1:0] m;
    logic [W-1:0] s2;
    logic         rise;
    if (rst) begin
      m_out = '0; m_prio = 1'b0; m_q.delete(); m_drop = 0;
      m_phase = 0; m_last = '0;
      for (int i = 0; i < 3; i++) begin g_hist[i] = '0; e_hist[i] = 1'b0; end
    end else begin
      if (req_valid != 2'b00) begin
        g = (req_valid == 2'b11) ? m_prio : req_valid[1];
        d = g ? req_data[W +: W] : req_data[0 +: W];
        m = g ? req_mask[W +: W] : req_mask[0 +: W];
        m_out  = (m_out & ~m) | (d & m);
        m_prio = !g;
      end
      if (m_phase < 10) m_phase++;
      s2   = g_hist[1];
      rise = e_hist[1] && !e_hist[2];
      if (m_q.size() > 0 && evt_ready) void'(m_q.pop_front());
      if (m_phase == 3) begin
        m_last = s2;
      end else if (m_phase >= 4) begin
        if (s2 != m_last || rise) begin
          if (m_q.size() < D) m_q.push_back('{gpio: s2, ext: rise});
          else if (m_drop < 255) m_drop++;
        end
        m_last = s2;
      end
      g_hist[2] = g_hist[1]; g_hist[1] = g_hist[0]; g_hist[0] = gpio_in;
      e_hist[2] = e_hist[1]; e_hist[1] = e_hist[0]; e_hist[0] = ext_clk;
    end
  endtask

  // One clock cycle: check combinational ready, clock, then check registered outputs.
  task automatic applyStimulus();
    #1;
    checkOutput("req_ready", 64'(req_ready), 64'(model_ready()));
    @(posedge clk);
    model_edge();
    #1;
    checkOutput("gpio_out", 64'(gpio_out), 64'(m_out));
    checkOutput("evt_valid", 64'(evt_valid), 64'(m_q.size() > 0));
    checkOutput("evt_gpio", 64'(evt_gpio), 64'((m_q.size() > 0) ? m_q[0].gpio : '0));
    checkOutput("evt_ext", 64'(evt_ext), 64'((m_q.size() > 0) ? m_q[0].ext : 1'b0));
    checkOutput("evt_drop_cnt", 64'(evt_drop_cnt), 64'(m_drop));
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = 2'b11;
    req_data  = {$urandom, $urandom, $urandom, $urandom};
    req_mask  = '1;
    evt_ready = 1'b0;
    #1;
    checkOutput("rst_ready_zero", 64'(req_ready), 64'(0));
    applyStimulus();
    checkOutput("rst_gpio_out", 64'(gpio_out), 64'(0));
    checkOutput("rst_evt_valid", 64'(evt_valid), 64'(0));
    checkOutput("rst_evt_gpio", 64'(evt_gpio), 64'(0));
    checkOutput("rst_evt_ext", 64'(evt_ext), 64'(0));
    checkOutput("rst_drop", 64'(evt_drop_cnt), 64'(0));
    rst       = 1'b0;
    req_valid = 2'b00;
  endtask

  typedef struct {
    logic [1:0]   valid;
    logic [W-1:0] d0;
    logic [W-1:0] d1;
    logic [W-1:0] m0;
    logic [W-1:0] m1;
    logic [1:0]   exp_ready;
    logic [W-1:0] exp_out;
  } arb_vec_t;

  arb_vec_t vecs [8];

  initial begin
    rst = 1'b0; req_valid = 2'b00; req_data = '0; req_mask = '0;
    gpio_in = '0; ext_clk = 1'b0; evt_ready = 1'b0;
    m_out = '0; m_prio = 1'b0; m_drop = 0; m_phase = 0; m_last = '0;
    for (int i = 0; i < 3; i++) begin g_hist[i] = '0; e_hist[i] = 1'b0; end

    vecs[0] = '{2'b11, 32'h1, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b01, 32'h1};
    vecs[1] = '{2'b11, 32'h1, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b10, 32'h2};
    vecs[2] = '{2'b11, 32'h1, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b01, 32'h1};
    vecs[3] = '{2'b11, 32'h1, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b10, 32'h2};
    vecs[4] = '{2'b01, 32'hFFFF_0000, 32'h0, 32'hFFFF_FFFF, 32'h0, 2'b01, 32'hFFFF_0000};
    vecs[5] = '{2'b01, 32'h0000_00FF, 32'h0, 32'h0000_0F0F, 32'h0, 2'b01, 32'hFFFF_000F};
    vecs[6] = '{2'b10, 32'h0, 32'h0, 32'h0, 32'hFFFF_0000, 2'b10, 32'h0000_000F};
    vecs[7] = '{2'b00, 32'h1234_5678, 32'h0, 32'hFFFF_FFFF, 32'h0, 2'b00, 32'h0000_000F};

    // Static pin value through reset and priming: no event expected.
    gpio_in = 32'hA5A5_0000;
    do_reset();
    repeat (6) applyStimulus();
    checkOutput("prime_no_event", 64'(evt_valid), 64'(0));
    checkOutput("prime_drop", 64'(evt_drop_cnt), 64'(0));
    checkOutput("prime_gpio_out", 64'(gpio_out), 64'(0));

    // Arbiter vector table.
    for (int i = 0; i < 8; i++) begin
      req_valid = vecs[i].valid;
      req_data  = {vecs[i].d1, vecs[i].d0};
      req_mask  = {vecs[i].m1, vecs[i].m0};
      #1;
      checkOutput($sformatf("tbl_ready_%0d", i), 64'(req_ready), 64'(vecs[i].exp_ready));
      applyStimulus();
      checkOutput($sformatf("tbl_out_%0d", i), 64'(gpio_out), 64'(vecs[i].exp_out));
    end
    req_valid = 2'b00;

    // Simultaneous pin change and ext_clk rise merge into one event after 3 edges.
    gpio_in = '0; ext_clk = 1'b0;
    do_reset();
    repeat (5) applyStimulus();
    gpio_in = 32'h1; ext_clk = 1'b1;
    applyStimulus();
    checkOutput("lat_e0", 64'(evt_valid), 64'(0));
    applyStimulus();
    checkOutput("lat_e1", 64'(evt_valid), 64'(0));
    applyStimulus();
    checkOutput("lat_e2_valid", 64'(evt_valid), 64'(1));
    checkOutput("lat_e2_gpio", 64'(evt_gpio), 64'(1));
    checkOutput("lat_e2_ext", 64'(evt_ext), 64'(1));
    evt_ready = 1'b1;
    applyStimulus();
    evt_ready = 1'b0;
    applyStimulus();
    checkOutput("merge_single", 64'(evt_valid), 64'(0));

    // Six changes with no consumer: four queued, two dropped.
    for (int k = 0; k < 6; k++) begin
      gpio_in = 32'(k + 2);
      applyStimulus();
    end
    repeat (3) applyStimulus();
    checkOutput("ovf_drop", 64'(evt_drop_cnt), 64'(2));
    checkOutput("ovf_head", 64'(evt_gpio), 64'(2));
    gpio_in = 32'h8;
    applyStimulus();
    applyStimulus();
    evt_ready = 1'b1;
    applyStimulus();
    evt_ready = 1'b0;
    checkOutput("fullpp_drop", 64'(evt_drop_cnt), 64'(2));
    checkOutput("fullpp_head", 64'(evt_gpio), 64'(3));
    evt_ready = 1'b1;
    repeat (4) applyStimulus();
    evt_ready = 1'b0;
    checkOutput("drain_empty", 64'(evt_valid), 64'(0));

    // Reset with three queued events discards them; nothing until RUN again.
    for (int k = 0; k < 3; k++) begin
      gpio_in = 32'(k + 16);
      applyStimulus();
    end
    repeat (2) applyStimulus();
    checkOutput("three_queued", 64'(evt_valid), 64'(1));
    do_reset();
    for (int k = 0; k < 3; k++) begin
      gpio_in = 32'(k + 32);
      applyStimulus();
      checkOutput($sformatf("post_rst_quiet_%0d", k), 64'(evt_valid), 64'(0));
    end
    applyStimulus();
    checkOutput("post_rst_run_event", 64'(evt_valid), 64'(1));

    // Randomized traffic against the model.
    for (int n = 0; n < 500; n++) begin
      rst       = ($urandom_range(0, 79) == 0);
      req_valid = 2'($urandom_range(0, 3));
      req_data  = {$urandom, $urandom};
      req_mask  = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) gpio_in = $urandom;
      if ($urandom_range(0, 3) == 0) ext_clk = ~ext_clk;
      evt_ready = ($urandom_range(0, 2) != 0);
      applyStimulus();
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
